// File: rtl/sine_pwm_ctrl.sv
// sine_pwm_ctrl: carrier tick, phase accumulator and soft amplitude ramp for the sine PWM datapath
module sine_pwm_ctrl #(
    parameter int CARRIER_DIV = 256,
    parameter int PHASE_W     = 16,
    parameter int ADDR_W      = 8,
    parameter int AMP_W       = 8,
    parameter int RAMP_STEP   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_freq,
    input  logic [AMP_W-1:0]   cfg_amp,
    output logic               carrier_tick,
    output logic [ADDR_W-1:0]  lut_addr,
    output logic [AMP_W-1:0]   amp_out,
    output logic               pwm_en,
    output logic               busy
);
    localparam int CW = (CARRIER_DIV > 2) ? $clog2(CARRIER_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CARRIER_DIV - 1);
    localparam logic [AMP_W:0] STEP = (AMP_W+1)'(RAMP_STEP);

    typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;
    state_t state, state_next;

    logic [CW-1:0]      cnt, cnt_next;
    logic [PHASE_W-1:0] phase, freq, sh_freq;
    logic [AMP_W-1:0]   amp, amp_next, target, sh_amp, amp_toward, amp_fall;
    logic [AMP_W:0]     amp_x, tgt_x, up;
    logic               pending, tick_next;

    assign amp_x      = {1'b0, amp};
    assign tgt_x      = {1'b0, target};
    assign up         = amp_x + STEP;
    assign amp_toward = (amp < target) ? ((up > tgt_x) ? target : up[AMP_W-1:0])
                      : ((amp_x > tgt_x + STEP) ? amp - STEP[AMP_W-1:0] : target);
    assign amp_fall   = (amp_x > STEP) ? amp - STEP[AMP_W-1:0] : '0;

    always_comb begin
        state_next = state;
        amp_next   = amp;
        case (state)
            IDLE: state_next = (start && !stop) ? RAMP_UP : IDLE;
            RAMP_UP: begin
                amp_next   = carrier_tick ? amp_toward : amp;
                state_next = stop ? RAMP_DOWN : (carrier_tick && amp_toward == target) ? RUN : RAMP_UP;
            end
            RUN: begin
                amp_next   = carrier_tick ? amp_toward : amp;
                state_next = stop ? RAMP_DOWN : RUN;
            end
            default: begin
                amp_next   = carrier_tick ? amp_fall : amp;
                state_next = (start && !stop) ? RAMP_UP : (carrier_tick && amp_fall == '0) ? IDLE : RAMP_DOWN;
            end
        endcase
        cnt_next  = (state == IDLE || state_next == IDLE) ? '0 : (cnt == LAST) ? '0 : cnt + 1'b1;
        tick_next = (state_next != IDLE) && (cnt_next == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            carrier_tick <= 1'b0;
            phase        <= '0;
            amp          <= '0;
            freq         <= '0;
            target       <= '0;
            sh_freq      <= '0;
            sh_amp       <= '0;
            pending      <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            carrier_tick <= tick_next;
            amp          <= amp_next;
            phase        <= (state_next == IDLE) ? '0 : carrier_tick ? phase + freq : phase;
            if (cfg_valid && !pending) begin
                sh_freq <= cfg_freq;
                sh_amp  <= cfg_amp;
                pending <= 1'b1;
            end else if (pending && (carrier_tick || state == IDLE)) begin
                freq    <= sh_freq;
                target  <= sh_amp;
                pending <= 1'b0;
            end
        end
    end

    assign cfg_ready = !pending;
    assign lut_addr  = phase[PHASE_W-1 -: ADDR_W];
    assign amp_out   = amp;
    assign pwm_en    = state != IDLE;
    assign busy      = state != IDLE;
endmodule

// File: tb/tb_sine_pwm_ctrl.sv
// tb_sine_pwm_ctrl: directed checks of ramping, config handshake, phase wrap and async reset
module tb_sine_pwm_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, cfg_valid = 1'b0;
    logic        cfg_ready, carrier_tick, pwm_en, busy;
    logic [15:0] cfg_freq = '0;
    logic [7:0]  cfg_amp = '0, lut_addr, amp_out;
    int          n_checks = 0, n_fail = 0;

    sine_pwm_ctrl #(.CARRIER_DIV(4), .PHASE_W(16), .ADDR_W(8), .AMP_W(8), .RAMP_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_freq(cfg_freq), .cfg_amp(cfg_amp),
        .carrier_tick(carrier_tick), .lut_addr(lut_addr), .amp_out(amp_out),
        .pwm_en(pwm_en), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cfg(input logic [15:0] f, input logic [7:0] a);
        cfg_freq = f; cfg_amp = a; cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        step(3);
        rst_n = 1'b1;
        step(1);
        chk("rst_amp", 32'(amp_out), 0);
        chk("rst_pwm_en", 32'(pwm_en), 0);
        chk("rst_lut", 32'(lut_addr), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tick", 32'(carrier_tick), 0);

        send_cfg(16'h0100, 8'd4);
        chk("idle_ready_low", 32'(cfg_ready), 0);
        step(1);
        chk("idle_ready_back", 32'(cfg_ready), 1);
        pulse_start;
        chk("start_pwm_en", 32'(pwm_en), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_amp", 32'(amp_out), 0);
        step(3);
        chk("tick_high", 32'(carrier_tick), 1);
        step(1);
        chk("tick_low", 32'(carrier_tick), 0);
        chk("up_amp1", 32'(amp_out), 1);
        chk("up_lut1", 32'(lut_addr), 1);
        for (int k = 2; k <= 4; k++) begin
            step(4);
            chk("up_amp", 32'(amp_out), 32'(k));
            chk("up_lut", 32'(lut_addr), 32'(k));
        end

        cfg_freq = 16'h0200; cfg_amp = 8'd4; cfg_valid = 1'b1;
        step(1);
        chk("run_ready_low1", 32'(cfg_ready), 0);
        step(2);
        cfg_valid = 1'b0;
        chk("run_ready_low3", 32'(cfg_ready), 0);
        chk("run_tick", 32'(carrier_tick), 1);
        step(1);
        chk("run_ready_back", 32'(cfg_ready), 1);
        chk("run_lut_old_freq", 32'(lut_addr), 5);
        step(4);
        chk("run_lut_step2", 32'(lut_addr), 7);

        send_cfg(16'h8000, 8'd4);
        step(3);
        chk("wrap_lut0", 32'(lut_addr), 32'h09);
        step(4);
        chk("wrap_lut1", 32'(lut_addr), 32'h89);
        step(4);
        chk("wrap_lut2", 32'(lut_addr), 32'h09);
        step(4);
        chk("wrap_lut3", 32'(lut_addr), 32'h89);

        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        step(3);
        chk("stop_wins_amp", 32'(amp_out), 3);
        chk("stop_wins_busy", 32'(busy), 1);
        pulse_start;
        step(3);
        chk("restart_amp", 32'(amp_out), 4);
        step(4);
        chk("restart_run_amp", 32'(amp_out), 4);

        #2 rst_n = 1'b0;
        #1;
        chk("async_amp", 32'(amp_out), 0);
        chk("async_pwm_en", 32'(pwm_en), 0);
        chk("async_lut", 32'(lut_addr), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_ready", 32'(cfg_ready), 1);
        step(2);
        rst_n = 1'b1;
        step(1);

        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("idle_stop_ignored", 32'(busy), 0);

        send_cfg(16'h0100, 8'd4);
        step(1);
        pulse_start;
        step(4);
        chk("up2_amp1", 32'(amp_out), 1);
        step(4);
        chk("up2_amp2", 32'(amp_out), 2);
        chk("up2_lut2", 32'(lut_addr), 2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(3);
        chk("down_amp1", 32'(amp_out), 1);
        chk("down_pwm_en", 32'(pwm_en), 1);
        step(4);
        chk("down_amp0", 32'(amp_out), 0);
        chk("down_pwm_off", 32'(pwm_en), 0);
        chk("down_lut0", 32'(lut_addr), 0);
        chk("down_busy", 32'(busy), 0);
        step(4);
        chk("idle_lut_hold", 32'(lut_addr), 0);
        chk("idle_tick_low", 32'(carrier_tick), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
